regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the single register-file write port (address to the write decoder, enable, data)
//  between the writeback stage and a long-latency unit (divider/load-miss return).
//  WB has priority; LU results queue in a small FIFO and drain into idle write slots.
//  A starvation counter forces a one-cycle WB stall so queued LU results always retire.
// PARAMETERS
//  WIDTH       32  data width of the write port
//  DEPTH       4   LU result FIFO entries (power of 2, >=2)
//  STARVE_MAX  8   consecutive blocked cycles before a forced drain (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  reset      in   1       synchronous, active-low reset
//  WBWrite    in   1       WB stage write request (RegWriteW)
//  WBAddr     in   5       WB destination register
//  WBData     in   WIDTH   WB result
//  LUValid    in   1       LU result valid
//  LUAddr     in   5       LU destination register
//  LUData     in   WIDTH   LU result
//  LUReady    out  1       FIFO can accept; transfer when LUValid & LUReady
//  WEn        out  1       write enable to register file / write decoder
//  WAddr      out  5       write address to write decoder
//  WData      out  WIDTH   write data
//  StallW     out  1       hold WB stage this cycle (forced drain)
//  FifoCount  out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  - Reset (reset==0 at edge): FIFO pointers/count=0, starve counter=0, state=NORMAL.
//    While reset low: WEn=0, StallW=0, LUReady=0. After release: LUReady=1, FifoCount=0.
//  - Outputs WEn/WAddr/WData/StallW combinational from state, FIFO head, WB inputs.
//  - FSM NORMAL: WBWrite=1 -> port grants WB (WAddr=WBAddr). Else FIFO non-empty -> port
//    writes head, pop. Else WEn=0.
//  - Starve counter: +1 each NORMAL cycle with FIFO non-empty and WB granted; cleared on pop.
//    Counter reaching STARVE_MAX -> next state DRAIN.
//  - DRAIN (exactly one cycle): StallW=1, WB write suppressed (WB retries next cycle),
//    head written and popped, counter cleared, next state NORMAL.
//  - LUReady = !full. Push when LUValid & LUReady. Push+pop same cycle legal when not full;
//    when full, no push even if a pop occurs that cycle (LUReady already low).
//  - Pointers wrap modulo DEPTH; FifoCount range 0..DEPTH.
//  - Register x0: any grant with address 0 drives WEn=0; slot still consumed (pop/WB done).
//  - Reset mid-operation: queued LU results discarded; LU side must reissue.
//  - Min LU latency 1 cycle (push, then pop next cycle if port idle).
// CONFIGURATION
//  RF_ARB_BYPASS_EN defined: LU push with FIFO empty, WBWrite=0, state NORMAL is written
//    directly the same cycle (WEn=1, WAddr=LUAddr) and not enqueued; LU latency 0.
//  Undefined: every LU result is enqueued; latency >=1 cycle.
// TESTING
//  1 reset=0 3 cycles, LUValid=1 -> WEn=0, LUReady=0; release -> LUReady=1, FifoCount=0.
//  2 WBWrite=1 WBAddr=5 WBData=32'hDEADBEEF -> same cycle WEn=1 WAddr=5 WData=DEADBEEF.
//  3 idle, LU push addr 7 data 32'h12 -> next cycle WEn=1 WAddr=7, FifoCount 1->0
//    (with RF_ARB_BYPASS_EN: same cycle write, FifoCount stays 0).
//  4 WBWrite=1 every cycle, 5 LU pushes -> 4 accepted, LUReady=0 at FifoCount=4.
//  5 WBWrite=1 every cycle, 1 LU queued (addr 9) -> StallW=1 for exactly one cycle,
//    8 cycles after push, WAddr=9; WB write retires the next cycle.
//  6 WBAddr=0 WBWrite=1 -> WEn=0; LU addr 0 queued -> popped with WEn=0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the WB stage / long-latency unit and the register-file arbiter.
// Direction is seen from the arbiter: slave receives requests, master drives them.
interface regfile_write_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                     WBWrite;
    logic [4:0]               WBAddr;
    logic [WIDTH-1:0]         WBData;
    logic                     LUValid;
    logic [4:0]               LUAddr;
    logic [WIDTH-1:0]         LUData;
    logic                     LUReady;
    logic                     WEn;
    logic [4:0]               WAddr;
    logic [WIDTH-1:0]         WData;
    logic                     StallW;
    logic [$clog2(DEPTH):0]   FifoCount;

    modport master (
        output WBWrite, WBAddr, WBData, LUValid, LUAddr, LUData,
        input  LUReady, WEn, WAddr, WData, StallW, FifoCount
    );

    modport slave (
        input  WBWrite, WBAddr, WBData, LUValid, LUAddr, LUData,
        output LUReady, WEn, WAddr, WData, StallW, FifoCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port: WB has priority, LU results queue and drain into idle slots.
// Latency: WB 0 cycles; LU >=1 cycle via FIFO (0 with RF_ARB_BYPASS_EN when the port is idle).
// Backpressure: LUReady = !full; after STARVE_MAX blocked cycles StallW holds WB one cycle.
module regfile_write_arbiter #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   rf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {NORMAL, DRAIN} state_t;

    typedef struct packed {
        logic [4:0]       addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve;
    state_t          state;

    logic            empty;
    logic            full;
    logic            ready;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            grant;
    logic            stall;
    logic            wb_blocked;
    logic [4:0]      gaddr;
    logic [WIDTH-1:0] gdata;
    entry_t          head;

    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        head       = mem[rd_ptr];
        grant      = 1'b0;
        gaddr      = '0;
        gdata      = '0;
        pop        = 1'b0;
        bypass     = 1'b0;
        stall      = 1'b0;
        wb_blocked = 1'b0;
        if (reset) begin
            if (state == DRAIN) begin
                // WB is held off this cycle and retries on the next one.
                stall = 1'b1;
                if (!empty) begin
                    grant = 1'b1;
                    pop   = 1'b1;
                    gaddr = head.addr;
                    gdata = head.data;
                end
            end else if (rf.WBWrite) begin
                grant      = 1'b1;
                gaddr      = rf.WBAddr;
                gdata      = rf.WBData;
                wb_blocked = !empty;
            end else if (!empty) begin
                grant = 1'b1;
                pop   = 1'b1;
                gaddr = head.addr;
                gdata = head.data;
            end
`ifdef RF_ARB_BYPASS_EN
            else if (rf.LUValid) begin
                grant  = 1'b1;
                bypass = 1'b1;
                gaddr  = rf.LUAddr;
                gdata  = rf.LUData;
            end
`endif
        end
        ready = reset && !full;
        push  = rf.LUValid && ready && !bypass;
    end

    // x0 is hardwired: the slot is still consumed, only the enable is dropped.
    assign rf.WEn       = grant && (gaddr != 5'd0);
    assign rf.WAddr     = gaddr;
    assign rf.WData     = gdata;
    assign rf.StallW    = stall;
    assign rf.LUReady   = ready;
    assign rf.FifoCount = count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: rf.LUAddr, data: rf.LUData};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
            state  <= NORMAL;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case (state)
                DRAIN: begin
                    starve <= '0;
                    state  <= NORMAL;
                end
                default: begin
                    if (pop) begin
                        starve <= '0;
                    end else if (wb_blocked) begin
                        starve <= starve + SW'(1);
                        if (starve == SW'(STARVE_MAX - 1)) state <= DRAIN;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised plus directed bench for regfile_write_arbiter against a queue-based reference model.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_regfile_write_arbiter;
    localparam int WIDTH      = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) rf ();

    regfile_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   blk;
    bit   drain;
    int   checks;
    int   failures;
    bit   last_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model at the falling edge, advance the model.
    task automatic step(input logic rst, input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                        input logic luv, input logic [4:0] lua, input logic [31:0] lud);
        bit          g, pop, byp, rdy;
        logic [4:0]  a;
        logic [31:0] d;
        bit          nd;
        @(posedge clk);
        #1;
        reset      = rst;
        rf.WBWrite = wbw;
        rf.WBAddr  = wba;
        rf.WBData  = wbd;
        rf.LUValid = luv;
        rf.LUAddr  = lua;
        rf.LUData  = lud;
        @(negedge clk);
        last_stall = rf.StallW;
        if (!rst) begin
            check("rst_wen", rf.WEn, 0);
            check("rst_stall", rf.StallW, 0);
            check("rst_ready", rf.LUReady, 0);
            mq.delete();
            blk   = 0;
            drain = 0;
            return;
        end
        g = 0; pop = 0; byp = 0; a = '0; d = '0;
        rdy = (mq.size() < DEPTH);
        if (drain) begin
            if (mq.size() > 0) begin
                g = 1; pop = 1; a = mq[0].a; d = mq[0].d;
            end
        end else if (wbw) begin
            g = 1; a = wba; d = wbd;
            if (mq.size() > 0) blk++;
        end else if (mq.size() > 0) begin
            g = 1; pop = 1; a = mq[0].a; d = mq[0].d;
        end
`ifdef RF_ARB_BYPASS_EN
        else if (luv) begin
            g = 1; byp = 1; a = lua; d = lud;
        end
`endif
        check("wen", rf.WEn, (g && a != 0));
        if (g && a != 0) begin
            check("waddr", rf.WAddr, a);
            check("wdata", rf.WData, d);
        end
        check("stall", rf.StallW, drain);
        check("ready", rf.LUReady, rdy);
        check("count", rf.FifoCount, mq.size());
        nd = 0;
        if (pop) begin
            void'(mq.pop_front());
            blk = 0;
        end else if (!drain && blk >= STARVE_MAX) begin
            nd = 1;
        end
        if (drain) blk = 0;
        if (luv && rdy && !byp) mq.push_back('{a: lua, d: lud});
        drain = nd;
    endtask

    initial begin
        int stall_cnt;
        checks = 0; failures = 0; blk = 0; drain = 0;
        reset = 1'b0;
        rf.WBWrite = 0; rf.WBAddr = '0; rf.WBData = '0;
        rf.LUValid = 0; rf.LUAddr = '0; rf.LUData = '0;

        // Reset held with LU traffic present, then release.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 5'd3, 32'h1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("post_rst_ready", rf.LUReady, 1);
        check("post_rst_count", rf.FifoCount, 0);

        step(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);

        step(1, 0, 0, 0, 1, 5'd7, 32'h12);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // FIFO fill under continuous WB traffic.
        for (int i = 0; i < 5; i++) step(1, 1, 5'd1 + 5'(i), $urandom, 1, 5'd10 + 5'(i), 32'(i));
        check("t4_count", rf.FifoCount, DEPTH);
        check("t4_ready", rf.LUReady, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0);

        // Starvation: a single queued result must force exactly one drain slot.
        stall_cnt = 0;
        step(1, 1, 5'd3, $urandom, 1, 5'd9, 32'h99);
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 5'd3, $urandom, 0, 0, 0);
            if (last_stall) stall_cnt++;
        end
        check("t5_stall_once", stall_cnt, 1);

        // Writes to x0 from both sources.
        step(1, 1, 5'd0, 32'hAAAA5555, 0, 0, 0);
        step(1, 0, 0, 0, 1, 5'd0, 32'h55);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            logic [4:0] wa, la;
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(($urandom_range(0, 80) != 0), ($urandom_range(0, 9) < 7), wa, $urandom,
                 ($urandom_range(0, 1) == 1), la, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
